// File: rtl/ipml_fifo_defs_pkg.sv
// Shared FIFO definitions: width helpers and the write/read operation encoding
// used by the register- and RAM-based FIFO variants.
package ipml_fifo_defs;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2_f(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Pointers wrap naturally, so they are exactly log2(DEPTH) bits (min 1).
  function automatic int ptr_width(input int depth);
    return (clog2_f(depth) < 1) ? 1 : clog2_f(depth);
  endfunction

  // Count must reach DEPTH itself, hence one extra bit.
  function automatic int count_width(input int depth);
    return clog2_f(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/ipml_fifo_ctrl.sv
// FIFO bookkeeping: read/write pointers, occupancy count, full/empty and
// almost flags. Callers pass only stored writes/reads (bypass excluded).
module ipml_fifo_ctrl
  import ipml_fifo_defs::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int PW       = ptr_width(DEPTH),
  localparam int CW       = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_op_e      op;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    op      = fifo_op_e'({wr_en, rd_en});
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      unique case (op)
        OP_WR: begin
          wptr_d  = wptr_q + PW'(1);
          count_d = count_q + CW'(1);
        end
        OP_RD: begin
          rptr_d  = rptr_q + PW'(1);
          count_d = count_q - CW'(1);
        end
        OP_BOTH: begin
          wptr_d = wptr_q + PW'(1);
          rptr_d = rptr_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr         = wptr_q;
  assign rptr         = rptr_q;
  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

endmodule

// File: rtl/ipml_reg_fifo_v2_0.sv
// Register-array FIFO with valid/ready on both sides, optional first-word
// fall-through bypass, synchronous flush, count and almost flags.
module ipml_reg_fifo_v2_0
  import ipml_fifo_defs::*;
#(
  parameter  int W           = 8,
  parameter  int DEPTH       = 4,
  parameter  int FALLTHROUGH = 0,
  parameter  int AF_LEVEL    = DEPTH - 1,
  parameter  int AE_LEVEL    = 1,
  localparam int PW          = ptr_width(DEPTH),
  localparam int CW          = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          data_in_valid,
  input  logic [W-1:0]  data_in,
  output logic          data_in_ready,
  input  logic          data_out_ready,
  output logic [W-1:0]  data_out,
  output logic          data_out_valid,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
);

  if (W < 1) begin : g_bad_width
    $error("ipml_reg_fifo_v2_0: W must be >= 1");
  end
  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("ipml_reg_fifo_v2_0: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("ipml_reg_fifo_v2_0: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("ipml_reg_fifo_v2_0: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, empty;
  logic          bypass, write, read, stored_wr, stored_rd;

  ipml_fifo_ctrl #(
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (stored_wr),
    .rd_en       (stored_rd),
    .wptr        (wptr),
    .rptr        (rptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  // A word that enters and leaves in the same bypass cycle never touches storage.
  always_comb begin
    bypass         = (FALLTHROUGH != 0) && empty;
    data_in_ready  = ~flush & ~full;
    data_out_valid = ~flush & (bypass ? data_in_valid : ~empty);
    data_out       = bypass ? data_in : mem_q[rptr];
    write          = data_in_valid & data_in_ready;
    read           = data_out_valid & data_out_ready;
    stored_wr      = write & ~(bypass & read);
    stored_rd      = read & ~bypass;
    mem_d          = mem_q;
    if (stored_wr) mem_d[wptr] = data_in;
  end

  // NOTE: the array is reset so data_out reads zero out of reset; it is small enough to be plain flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ipml_reg_fifo_v2_0.sv
// Scoreboard bench: a registered-output FIFO and a fall-through FIFO share one
// stimulus stream; each has its own queue model and an output monitor.
module tb_ipml_reg_fifo_v2_0;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         din_v;
  logic [W-1:0] din;
  logic         dout_r;

  logic         rdy [2];
  logic         dv  [2];
  logic [W-1:0] dout[2];
  logic [2:0]   cnt [2];
  logic         af  [2];
  logic         ae  [2];

  int           checks   = 0;
  int           failures = 0;
  int           mcnt[2];
  logic [W-1:0] exp_q[2][$];

  always #5 clk = ~clk;

  ipml_reg_fifo_v2_0 #(.W(W), .DEPTH(DEPTH), .FALLTHROUGH(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .data_in_valid(din_v), .data_in(din), .data_in_ready(rdy[0]),
    .data_out_ready(dout_r), .data_out(dout[0]), .data_out_valid(dv[0]),
    .count(cnt[0]), .almost_full(af[0]), .almost_empty(ae[0])
  );

  ipml_reg_fifo_v2_0 #(.W(W), .DEPTH(DEPTH), .FALLTHROUGH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .data_in_valid(din_v), .data_in(din), .data_in_ready(rdy[1]),
    .data_out_ready(dout_r), .data_out(dout[1]), .data_out_valid(dv[1]),
    .count(cnt[1]), .almost_full(af[1]), .almost_empty(ae[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: a FIFO holds accepted words in order; flow rules come from occupancy.
  task automatic model_cycle();
    for (int i = 0; i < 2; i++) begin
      int   pre;
      logic e_rdy, e_v, wr, rd;
      pre   = mcnt[i];
      e_rdy = !flush && (pre != DEPTH);
      e_v   = !flush && ((pre != 0) || (i == 1 && din_v));
      wr    = din_v && e_rdy;
      rd    = e_v && dout_r;
      check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(e_rdy));
      check($sformatf("valid%0d", i), 32'(dv[i]), 32'(e_v));
      check($sformatf("count%0d", i), 32'(cnt[i]), 32'(pre));
      check($sformatf("almost_full%0d", i), 32'(af[i]), 32'(pre >= DEPTH - 1));
      check($sformatf("almost_empty%0d", i), 32'(ae[i]), 32'(pre <= 1));
      if (wr) exp_q[i].push_back(din);
      if (flush) begin
        exp_q[i].delete();
        mcnt[i] = 0;
      end else begin
        mcnt[i] = pre + int'(wr) - int'(rd);
      end
    end
  endtask

  // Monitor: every handshake on the output side must deliver the oldest expected word.
  always @(negedge clk) begin
    #1;
    if (!rst && dout_r) begin
      for (int i = 0; i < 2; i++) begin
        if (dv[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("underflow%0d", i), 32'(1), 32'(0));
          end else begin
            check($sformatf("data_out%0d", i), 32'(dout[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  // Entered at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    din_v  = v;
    din    = d;
    dout_r = r;
    flush  = f;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      mcnt[i] = 0;
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_ready%0d", tag, i), 32'(rdy[i]), 32'(1));
      check($sformatf("%s_count%0d", tag, i), 32'(cnt[i]), 32'(0));
      check($sformatf("%s_af%0d", tag, i), 32'(af[i]), 32'(0));
      check($sformatf("%s_ae%0d", tag, i), 32'(ae[i]), 32'(1));
    end
    check({tag, "_valid0"}, 32'(dv[0]), 32'(0));
    check({tag, "_dout0"}, 32'(dout[0]), 32'(0));
    check({tag, "_valid1"}, 32'(dv[1]), 32'(din_v));
    check({tag, "_dout1"}, 32'(dout[1]), 32'(din));
  endtask

  initial begin
    rst    = 1'b1;
    flush  = 1'b0;
    din_v  = 1'b0;
    din    = '0;
    dout_r = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill with the consumer stalled; the fifth word must be held off.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);

    // Drain from full, then one idle cycle of empty.
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Steady read+write at count 2 across several pointer wraps.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Both empty: the fall-through instance passes 0xA5 straight through.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 3 with a write pending; the next write is the first read back.
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    step(1'b1, 8'h63, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset pulse between clock edges at count 2.
    step(1'b1, 8'h81, 1'b0, 1'b0);
    step(1'b1, 8'h82, 1'b0, 1'b0);
    din_v  = 1'b1;
    din    = 8'h3C;
    dout_r = 1'b0;
    flush  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    reset_checks("arst");
    rst    = 1'b0;
    din_v  = 1'b0;
    din    = '0;
    clear_model();
    @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) check($sformatf("leftover%0d", i), 32'(exp_q[i].size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
